// File: rtl/blp_pkg.sv
// blp_pkg: shared FSM encoding and ms-to-cycles helpers for board-I/O blocks.
package blp_pkg;

    typedef logic [1:0] blp_state_t;

    localparam blp_state_t ST_RELEASED     = 2'd0;
    localparam blp_state_t ST_PRESS_WAIT   = 2'd1;
    localparam blp_state_t ST_PUSHED       = 2'd2;
    localparam blp_state_t ST_RELEASE_WAIT = 2'd3;

    function automatic int ms_to_cycles(input int freq_hz, input int ms);
        return (freq_hz / 1000) * ms;
    endfunction

    function automatic int at_least_one(input int v);
        return (v < 1) ? 1 : v;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/button_debounce.sv
// button_debounce: synchronizes and debounces a board button, producing level,
// press/release/long-press strobes and a toggle.
module button_debounce
    import blp_pkg::*;
#(
    parameter int clock_freq    = 24_000_000,
    parameter int debounce_ms   = 10,
    parameter int long_press_ms = 1000,
    parameter bit active_low    = 1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic button,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press_pulse,
    output logic toggle
);

    localparam int DEBOUNCE_COUNT = at_least_one(ms_to_cycles(clock_freq, debounce_ms));
    localparam int LONG_COUNT     = at_least_one(ms_to_cycles(clock_freq, long_press_ms));
    localparam int DW             = $clog2(DEBOUNCE_COUNT + 1);
    localparam int LW             = $clog2(LONG_COUNT + 1);
    localparam bit DEB_ONE        = (DEBOUNCE_COUNT == 1);

    // The entry edge into a wait state is the first stable sample, so the
    // counter holds (samples seen - 1) and acceptance is one short of DEBOUNCE_COUNT-1.
    localparam logic [DW-1:0] DEB_LAST  = DW'((DEBOUNCE_COUNT >= 2) ? DEBOUNCE_COUNT - 2 : 0);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_COUNT - 1);
    localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_COUNT);

    logic          btn_sync;
    logic          push_s;
    blp_state_t    state_q, state_d;
    logic [DW-1:0] stab_q, stab_d;
    logic [LW-1:0] hold_q, hold_d;
    logic          pressed_q, pressed_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          toggle_q, toggle_d;
    logic          go_push, go_release;

    sync_2ff #(
        .RESET_VAL(active_low ? 1'b1 : 1'b0)
    ) u_sync (
        .clock  (clock),
        .reset_n(reset_n),
        .d_i    (button),
        .q_o    (btn_sync)
    );

    assign push_s = active_low ? ~btn_sync : btn_sync;

    always_comb begin
        state_d    = state_q;
        stab_d     = stab_q;
        hold_d     = hold_q;
        pressed_d  = pressed_q;
        toggle_d   = toggle_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        long_d     = 1'b0;
        go_push    = 1'b0;
        go_release = 1'b0;
        case (state_q)
            ST_RELEASED: begin
                if (push_s) begin
                    state_d = ST_PRESS_WAIT;
                    stab_d  = '0;
                    go_push = DEB_ONE;
                end
            end
            ST_PRESS_WAIT: begin
                if (!push_s)
                    state_d = ST_RELEASED;
                else if (stab_q == DEB_LAST)
                    go_push = 1'b1;
                else
                    stab_d = stab_q + 1'b1;
            end
            ST_PUSHED: begin
                hold_d = (hold_q == LONG_MAX) ? hold_q : hold_q + 1'b1;
                long_d = (hold_q == LONG_LAST);
                if (!push_s) begin
                    state_d    = ST_RELEASE_WAIT;
                    stab_d     = '0;
                    go_release = DEB_ONE;
                end
            end
            default: begin
                // A bounce back to pushed keeps the hold count so a long press still lands.
                if (push_s)
                    state_d = ST_PUSHED;
                else if (stab_q == DEB_LAST)
                    go_release = 1'b1;
                else
                    stab_d = stab_q + 1'b1;
            end
        endcase
        if (go_push) begin
            state_d   = ST_PUSHED;
            pressed_d = 1'b1;
            press_d   = 1'b1;
            toggle_d  = ~toggle_q;
            hold_d    = '0;
        end
        if (go_release) begin
            state_d   = ST_RELEASED;
            pressed_d = 1'b0;
            release_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_RELEASED;
            stab_q    <= '0;
            hold_q    <= '0;
            pressed_q <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            toggle_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            stab_q    <= stab_d;
            hold_q    <= hold_d;
            pressed_q <= pressed_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            toggle_q  <= toggle_d;
        end
    end

    assign pressed          = pressed_q;
    assign press_pulse      = press_q;
    assign release_pulse    = release_q;
    assign long_press_pulse = long_q;
    assign toggle           = toggle_q;

endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: randomized and directed stimulus against a run-length reference model with an event scoreboard.
module tb_button_debounce;

    localparam int DC = 4;
    localparam int LC = 10;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic button  = 1'b1;
    logic pressed, press_pulse, release_pulse, long_press_pulse, toggle;

    button_debounce #(
        .clock_freq   (1000),
        .debounce_ms  (4),
        .long_press_ms(10),
        .active_low   (1)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .button          (button),
        .pressed         (pressed),
        .press_pulse     (press_pulse),
        .release_pulse   (release_pulse),
        .long_press_pulse(long_press_pulse),
        .toggle          (toggle)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         cyc;
        logic [4:0] v;
    } ev_t;

    ev_t sb[$];
    int  cyc = 0;
    int  total = 0;
    int  bad = 0;
    int  press_cnt = 0, release_cnt = 0, long_cnt = 0;
    int  last_press = -1000, last_long = -1000;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: the debounced level flips once DC consecutive synchronized
    // samples disagree with it; hold time accrues only while stably pushed.
    initial begin
        bit b1, b2, lvl, tog, s, p, r, l;
        int run, hold;
        b1 = 1; b2 = 1; lvl = 0; tog = 0; run = 0; hold = 0;
        forever begin
            @(posedge clock);
            cyc++;
            if (!reset_n) begin
                b1 = 1; b2 = 1; lvl = 0; tog = 0; run = 0; hold = 0;
            end else begin
                s  = !b2;
                b2 = b1;
                b1 = button;
                p = 0; r = 0; l = 0;
                if (lvl && run == 0 && hold < LC) begin
                    hold++;
                    l = (hold == LC);
                end
                if (s != lvl) begin
                    run++;
                    if (run == DC) begin
                        lvl = s;
                        run = 0;
                        p = s;
                        r = !s;
                        if (s) begin
                            tog  = !tog;
                            hold = 0;
                        end
                    end
                end else
                    run = 0;
                if (p || r || l)
                    sb.push_back('{cyc, {p, r, l, lvl, tog}});
            end
        end
    end

    initial begin
        ev_t e;
        forever begin
            @(negedge clock);
            if (reset_n) begin
                while (sb.size() > 0 && sb[0].cyc < cyc) begin
                    total++;
                    bad++;
                    $display("FAIL missed_event: no pulse, want %b at cycle %0d", sb[0].v, sb[0].cyc);
                    void'(sb.pop_front());
                end
                if (press_pulse || release_pulse || long_press_pulse) begin
                    if (press_pulse) begin press_cnt++; last_press = cyc; end
                    if (release_pulse) release_cnt++;
                    if (long_press_pulse) begin long_cnt++; last_long = cyc; end
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_pulse: got %b want none at cycle %0d",
                                 {press_pulse, release_pulse, long_press_pulse}, cyc);
                    end else begin
                        e = sb.pop_front();
                        chk("event_cycle", cyc, e.cyc);
                        chk("event_outputs", int'({press_pulse, release_pulse, long_press_pulse, pressed, toggle}), int'(e.v));
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic drive(input bit v, input int n);
        button = v;
        step(n);
    endtask

    initial begin
        int e, r, p0, r0, l0;
        step(3);
        chk("reset_outputs", int'({pressed, press_pulse, release_pulse, long_press_pulse, toggle}), 0);
        reset_n = 1'b1;
        step(3);

        e = cyc;
        drive(0, 20);
        chk("press_latency", last_press - e, 6);
        chk("long_latency", last_long - e, 16);
        chk("level_after_press", int'({pressed, toggle}), 3);
        drive(1, 12);
        chk("level_after_release", int'(pressed), 0);

        p0 = press_cnt; r0 = release_cnt;
        drive(0, 3); drive(1, 1); drive(0, 3); drive(1, 12);
        chk("bounce_no_press", press_cnt - p0, 0);
        chk("bounce_no_release", release_cnt - r0, 0);
        chk("bounce_level", int'(pressed), 0);

        r0 = release_cnt; l0 = long_cnt;
        drive(0, 8); drive(1, 2); drive(0, 20);
        chk("glitch_no_release", release_cnt - r0, 0);
        chk("glitch_long_once", long_cnt - l0, 1);
        chk("glitch_pressed", int'(pressed), 1);
        drive(1, 12);
        chk("glitch_final_release", release_cnt - r0, 1);

        p0 = press_cnt; r0 = release_cnt; l0 = long_cnt;
        drive(0, 8); drive(1, 12); drive(0, 8); drive(1, 12);
        chk("two_press_count", press_cnt - p0, 2);
        chk("two_release_count", release_cnt - r0, 2);
        chk("two_no_long", long_cnt - l0, 0);
        chk("two_toggle", int'(toggle), 0);

        l0 = long_cnt;
        drive(0, 11);
        reset_n = 1'b0;
        #1;
        chk("reset_clears", int'({pressed, press_pulse, release_pulse, long_press_pulse, toggle}), 0);
        step(2);
        reset_n = 1'b1;
        r = cyc;
        step(20);
        chk("reset_repress_latency", last_press - r, 6);
        chk("reset_long_latency", last_long - r, 16);
        chk("reset_long_once", long_cnt - l0, 1);
        drive(1, 12);

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 14) == 0) begin
                reset_n = 1'b0;
                step($urandom_range(1, 3));
                reset_n = 1'b1;
            end
            drive(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 4) == 0) ? $urandom_range(12, 25) : $urandom_range(1, 8));
        end
        drive(1, 15);
        chk("queue_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 The block SHALL have parameter clock_freq, default 24_000_000, meaning input clock frequency in Hz.
REQ-002 The block SHALL have parameter debounce_ms, default 10, meaning the required stable time before a level change is accepted.
REQ-003 The block SHALL have parameter long_press_ms, default 1000, meaning the hold time, measured from accepted press, that flags a long press.
REQ-004 The block SHALL have parameter active_low, default 1, meaning raw button reads 0 when pushed.
REQ-005 The block SHALL have port clock, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port button, input, 1 bit: raw asynchronous board button.
REQ-008 The block SHALL have port pressed, output, 1 bit: debounced level, 1 = pushed.
REQ-009 The block SHALL have port press_pulse, output, 1 bit: one-cycle strobe on accepted press.
REQ-010 The block SHALL have port release_pulse, output, 1 bit: one-cycle strobe on accepted release.
REQ-011 The block SHALL have port long_press_pulse, output, 1 bit: one-cycle strobe when a hold reaches long_press_ms.
REQ-012 The block SHALL have port toggle, output, 1 bit: inverts on every accepted press, suitable to drive an LED directly.

Function
REQ-013 button SHALL pass through a 2-flop synchronizer, then be inverted when active_low=1, giving internal level s (1 = pushed).
REQ-014 DEBOUNCE_COUNT SHALL equal (clock_freq/1000)*debounce_ms, and LONG_COUNT SHALL equal (clock_freq/1000)*long_press_ms, both evaluated at elaboration; counter widths SHALL be $clog2(value+1), with no overflow possible.
REQ-015 The FSM SHALL have states RELEASED, PRESS_WAIT, PUSHED and RELEASE_WAIT.
REQ-016 In RELEASED, s=1 SHALL move the FSM to PRESS_WAIT with stable counter cleared to 0.
REQ-017 In PRESS_WAIT, the counter SHALL increment each cycle s=1; s=0 SHALL return the FSM to RELEASED with no output change (bounce rejected).
REQ-018 In PRESS_WAIT, when the counter reaches DEBOUNCE_COUNT-1 with s=1, the FSM SHALL enter PUSHED and, on that same edge, set pressed=1, pulse press_pulse for one cycle, invert toggle and clear the hold counter.
REQ-019 In PUSHED, the hold counter SHALL increment each cycle and saturate at LONG_COUNT.
REQ-020 In PUSHED, long_press_pulse SHALL fire exactly once per press, on the cycle the hold counter reaches LONG_COUNT.
REQ-021 In PUSHED, s=0 SHALL move the FSM to RELEASE_WAIT with the stable counter cleared.
REQ-022 RELEASE_WAIT SHALL mirror PRESS_WAIT: s=1 returns the FSM to PUSHED with the hold counter kept (not cleared); DEBOUNCE_COUNT consecutive s=0 cycles enter RELEASED with pressed=0 and a one-cycle release_pulse.
REQ-023 pressed SHALL remain 1 throughout RELEASE_WAIT and 0 throughout PRESS_WAIT.
REQ-024 Latency from a clean raw edge to pressed/press_pulse SHALL be 2 + DEBOUNCE_COUNT cycles; release latency SHALL be identical.
REQ-025 press_pulse and release_pulse SHALL never be asserted in the same cycle; long_press_pulse SHALL never coincide with press_pulse.
REQ-026 If DEBOUNCE_COUNT evaluates to 0, it SHALL be treated as 1.

Reset
REQ-027 While reset_n=0, the block SHALL force: FSM=RELEASED, counters=0, synchronizer flops=released level, pressed=0, all pulses=0, toggle=0.
REQ-028 Reset asserted mid-debounce or mid-hold SHALL abort the operation with no pulse emitted; after deassertion, a held button SHALL be re-accepted only after a full 2 + DEBOUNCE_COUNT cycles.

Structure
REQ-029 State encoding and the ms-to-cycles conversion SHALL live in a shared package, blp_pkg, for reuse by other board-I/O blocks.
REQ-030 The 2-flop synchronizer SHALL be a separate sub-module, sync_2ff, with its reset value as a parameter; all remaining logic SHALL be flat.

Verification (clock_freq=1000, debounce_ms=4, long_press_ms=10 => DEBOUNCE_COUNT=4, LONG_COUNT=10; active_low=1)
REQ-031 Clean press: button 1->0 held 20 cycles -> press_pulse on cycle 6 after the edge, pressed=1, toggle=1; long_press_pulse 10 cycles later.
REQ-032 Bounce: button low for 3 cycles, high for 1, low for 3, then high -> no pulses; pressed stays 0.
REQ-033 Release glitch: while pushed, button high for 2 cycles then low -> no release_pulse; long_press_pulse still fires once at hold count 10.
REQ-034 Two clean presses of 8 cycles each -> two press_pulses, two release_pulses, no long_press_pulse, toggle back to 0.
REQ-035 reset_n pulsed low at hold count 5 with button held -> outputs cleared immediately; press_pulse 6 cycles after reset_n rises; no stale long_press_pulse.
